// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: write-back slot to MEM, multi-cycle scratch fed back to EX,
// and a saturating count of bubbles inserted into MEM.
module ex_mem_reg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned STALL_W = 6,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned PERF_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic                ex_we,
  input  logic [ADDR_W-1:0]   ex_waddr,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic [2*DATA_W-1:0] ex_hilo_tmp,
  input  logic [CNT_W-1:0]    ex_cnt,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_valid,
  output logic [2*DATA_W-1:0] hilo_tmp_o,
  output logic [CNT_W-1:0]    cnt_o,
  output logic [PERF_W-1:0]   bubble_cnt
);

  localparam logic [PERF_W-1:0] PerfOne = {{(PERF_W-1){1'b0}}, 1'b1};

  logic bubble;
  logic advance;

  // Only the EX/MEM stall bits matter; stall[4] without stall[3] falls through to advance.
  assign bubble  = stall[3] & ~stall[4];
  assign advance = ~stall[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      mem_valid  <= 1'b0;
      hilo_tmp_o <= '0;
      cnt_o      <= '0;
      bubble_cnt <= '0;
    end else if (flush) begin
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      mem_valid  <= 1'b0;
      hilo_tmp_o <= '0;
      cnt_o      <= '0;
    end else if (bubble) begin
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      mem_valid  <= 1'b0;
      // Keep the partial result alive for EX's next attempt.
      hilo_tmp_o <= ex_hilo_tmp;
      cnt_o      <= ex_cnt;
      if (bubble_cnt != '1) begin
        bubble_cnt <= bubble_cnt + PerfOne;
      end
    end else if (advance) begin
      mem_we     <= ex_we;
      mem_waddr  <= ex_waddr;
      mem_wdata  <= ex_wdata;
      mem_valid  <= 1'b1;
      hilo_tmp_o <= '0;
      cnt_o      <= '0;
    end
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline register between the EX stage and the MEM stage of the 5-stage in-order core.
- Captures EX write-back results (write enable, destination address, data) and presents them to MEM one cycle later.
- Honours the global stall vector and flush: holds, inserts a bubble, or clears as required.
- Feeds a multi-cycle scratch state (partial 64-bit result plus step counter) back to EX so multi-cycle ALU ops can survive a stall. Keeps a saturating count of bubbles it has inserted.

Parameters:
- DATA_W, 32, register/data width.
- ADDR_W, 5, register-file address width.
- STALL_W, 6, stall vector width (bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB).
- CNT_W, 2, multi-cycle step counter width.
- PERF_W, 16, bubble counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- stall  in  STALL_W  stage stall request vector
- flush  in  1  pipeline flush (exception/redirect)
- ex_we  in  1  EX write enable
- ex_waddr  in  ADDR_W  EX destination register
- ex_wdata  in  DATA_W  EX result
- ex_hilo_tmp  in  2*DATA_W  EX partial multi-cycle result
- ex_cnt  in  CNT_W  EX multi-cycle step count
- mem_we  out  1  registered write enable to MEM
- mem_waddr  out  ADDR_W  registered destination
- mem_wdata  out  DATA_W  registered result
- mem_valid  out  1  1 = slot holds a real instruction, 0 = bubble
- hilo_tmp_o  out  2*DATA_W  scratch fed back to EX
- cnt_o  out  CNT_W  step count fed back to EX
- bubble_cnt  out  PERF_W  saturating count of bubbles inserted

Behaviour:
- All outputs are registers updated only on the rising clk edge. Nothing is combinational from the inputs.
- Reset (rst=1, synchronous): every output is set to 0. Reset has top priority and may occur mid multi-cycle op; scratch state is discarded.
- Priority per cycle is rst > flush > bubble > advance > hold.
- Flush (flush=1):
  - mem_we, mem_waddr, mem_wdata, mem_valid, hilo_tmp_o and cnt_o are all set to 0.
  - bubble_cnt is unchanged.
  - Flush overrides any stall combination.
- Bubble (stall[3]=1 and stall[4]=0): EX is stalled while MEM proceeds.
  - mem_we, mem_waddr, mem_wdata and mem_valid are set to 0.
  - hilo_tmp_o <= ex_hilo_tmp and cnt_o <= ex_cnt, preserving the partial result for EX's next cycle.
  - bubble_cnt increments by 1 and saturates at all-ones (no wrap).
- Advance (stall[3]=0):
  - mem_* <= ex_* and mem_valid <= 1.
  - hilo_tmp_o and cnt_o are set to 0, since a multi-cycle op completes when EX releases its stall.
- Hold (stall[3]=1 and stall[4]=1): all outputs keep their value, bubble_cnt included.
- Stall vectors with stall[4]=1 and stall[3]=0 are illegal (stalls propagate upstream). The block treats them as Advance; verification flags them with an assertion.
- Latency is 1 cycle from EX result to the mem_* outputs. There is no combinational bypass.
- Widths: mem_waddr and mem_wdata are passed through unchanged. cnt_o is captured verbatim with no arithmetic; EX owns the increment.
- Bubble detection uses only stall[3] and stall[4]; the other stall bits are ignored.

Test Plan:
- Reset then advance: rst=1 for 2 cycles, then ex_we=1, ex_waddr=5'd3, ex_wdata=32'h0000_F0F0 with stall=0 → after reset all outputs are 0. One cycle later mem_we=1, mem_waddr=3, mem_wdata=32'h0000_F0F0, mem_valid=1.
- Bubble with scratch: stall=6'b001111, ex_hilo_tmp=64'h1234_5678_9ABC_DEF0, ex_cnt=2'd1 for 2 cycles → mem_we=0, mem_valid=0, hilo_tmp_o=64'h1234_5678_9ABC_DEF0, cnt_o=1, bubble_cnt goes 0→1→2. Then stall=0 → cnt_o=0, hilo_tmp_o=0 and ex_* is captured.
- Hold: a valid result is latched, then stall=6'b011111 for 3 cycles while ex_wdata changes → mem_wdata stays constant and bubble_cnt is unchanged.
- Flush priority: flush=1 with stall=6'b001111 and ex_we=1 → next cycle all mem_* are 0, cnt_o=0, hilo_tmp_o=0, bubble_cnt unchanged.
- Saturation: preload by running 65535 bubble cycles, then 3 more bubbles → bubble_cnt stays 16'hFFFF.
- Reset mid-op: during a bubble with cnt_o=2, assert rst for 1 cycle → all outputs are 0 on the next edge.
